// File: rtl/fetch_prefetch_unit_if.sv
// Fetch-stage bus bundle: IMEM request/response, branch redirect, decode handshake and PC observation.
// The master modport is the fetch unit; the slave modport is the surrounding memory/decode environment.
interface fetch_prefetch_unit_if #(
    parameter int unsigned PC_W    = 16,
    parameter int unsigned INSTR_W = 16
);
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [PC_W-1:0]    imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               if_valid;
    logic               if_ready;
    logic [INSTR_W-1:0] if_instr;
    logic [PC_W-1:0]    if_pc;
    logic [PC_W-1:0]    PCOutput;
    logic [PC_W-1:0]    IFAdderOutput;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, PCOutput, IFAdderOutput,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, PCOutput, IFAdderOutput,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: PC register/adder, in-order prefetch queue with alloc/fill/head pointers,
// and redirect flush that counts in-flight responses which must be discarded when they return.
module fetch_prefetch_unit_chk (
    input logic clk,
    input logic reset_n,
    input logic rsp_valid_i,
    input logic redirect_i,
    input logic drop_zero_i,
    input logic pend_zero_i
);
    orphan_rsp_a : assert property (@(posedge clk) disable iff (!reset_n)
        !(rsp_valid_i && !redirect_i && drop_zero_i && pend_zero_i));
endmodule

module fetch_prefetch_unit #(
    parameter int unsigned     PC_W     = 16,
    parameter int unsigned     INSTR_W  = 16,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     PC_INC   = 2,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input logic            clk,
    input logic            reset_n,
    fetch_prefetch_unit_if.master bus
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned DROP_W = $clog2(DEPTH + 1) + 1;

    localparam logic [PTR_W-1:0]  PTR_ZERO   = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [DROP_W-1:0] DROP_ZERO  = {DROP_W{1'b0}};
    localparam logic [DROP_W-1:0] DROP_ONE   = {{(DROP_W-1){1'b0}}, 1'b1};
    localparam logic [DROP_W:0]   DSUM_ZERO  = {(DROP_W+1){1'b0}};
    localparam logic [DROP_W:0]   DSUM_ONE   = {{DROP_W{1'b0}}, 1'b1};
    localparam logic [DROP_W:0]   DROP_MAX   = {1'b0, {DROP_W{1'b1}}};

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PTR_W-1:0]   alloc_q, alloc_d, fill_q, fill_d, head_q, head_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   pend_q, pend_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic [DROP_W:0]    drop_sum_s;

    logic [PC_W-1:0]    ent_pc_q    [DEPTH];
    logic [INSTR_W-1:0] ent_instr_q [DEPTH];
    logic [DEPTH-1:0]   ent_filled_q;

    logic [PC_W-1:0]    adder_s;
    logic               req_valid_s, req_fire_s, if_valid_s, consume_s, rsp_drop_s, rsp_fill_s;

    assign adder_s     = pc_q + PC_W'(PC_INC);
    // Full queue blocks requests even when the head is consumed this cycle.
    assign req_valid_s = reset_n && (count_q < CNT_FULL) && !bus.redirect_valid;
    assign req_fire_s  = req_valid_s && bus.imem_req_ready;
    assign if_valid_s  = !bus.redirect_valid && (count_q != CNT_ZERO) && ent_filled_q[head_q];
    assign consume_s   = if_valid_s && bus.if_ready;
    assign rsp_drop_s  = bus.imem_rsp_valid && !bus.redirect_valid && (drop_q != DROP_ZERO);
    assign rsp_fill_s  = bus.imem_rsp_valid && !bus.redirect_valid && (drop_q == DROP_ZERO)
                         && (pend_q != CNT_ZERO);

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = pc_q;
    assign bus.PCOutput       = pc_q;
    assign bus.IFAdderOutput  = adder_s;
    assign bus.if_valid       = if_valid_s;
    assign bus.if_instr       = (count_q != CNT_ZERO) ? ent_instr_q[head_q] : {INSTR_W{1'b0}};
    assign bus.if_pc          = (count_q != CNT_ZERO) ? ent_pc_q[head_q] : {PC_W{1'b0}};

    // Next-state for PC, pointers, occupancy, pending fills and drop accounting.
    always_comb begin
        pc_d    = pc_q;
        alloc_d = alloc_q;
        fill_d  = fill_q;
        head_d  = head_q;
        count_d = count_q;
        pend_d  = pend_q;
        drop_d  = drop_q;

        drop_sum_s = (DROP_W+1)'(pend_q) + (DROP_W+1)'(drop_q);
        if (bus.imem_rsp_valid && (drop_sum_s != DSUM_ZERO)) begin
            drop_sum_s = drop_sum_s - DSUM_ONE;
        end else begin
            drop_sum_s = drop_sum_s;
        end

        if (bus.redirect_valid) begin
            pc_d    = bus.redirect_pc;
            alloc_d = PTR_ZERO;
            fill_d  = PTR_ZERO;
            head_d  = PTR_ZERO;
            count_d = CNT_ZERO;
            pend_d  = CNT_ZERO;
            drop_d  = (drop_sum_s > DROP_MAX) ? DROP_MAX[DROP_W-1:0] : drop_sum_s[DROP_W-1:0];
        end else begin
            if (req_fire_s) begin
                pc_d    = adder_s;
                alloc_d = alloc_q + PTR_ONE;
            end else begin
                pc_d    = pc_q;
            end
            if (rsp_fill_s) begin
                fill_d = fill_q + PTR_ONE;
            end else begin
                fill_d = fill_q;
            end
            if (consume_s) begin
                head_d = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
            if (rsp_drop_s) begin
                drop_d = drop_q - DROP_ONE;
            end else begin
                drop_d = drop_q;
            end
            case ({req_fire_s, consume_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            case ({req_fire_s, rsp_fill_s})
                2'b10:   pend_d = pend_q + CNT_ONE;
                2'b01:   pend_d = pend_q - CNT_ONE;
                default: pend_d = pend_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC;
            alloc_q <= PTR_ZERO;
            fill_q  <= PTR_ZERO;
            head_q  <= PTR_ZERO;
            count_q <= CNT_ZERO;
            pend_q  <= CNT_ZERO;
            drop_q  <= DROP_ZERO;
        end else begin
            pc_q    <= pc_d;
            alloc_q <= alloc_d;
            fill_q  <= fill_d;
            head_q  <= head_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
        end
    end

    // Queue entry storage: PC captured at request, instruction and filled flag at response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_pc_q[i]    <= {PC_W{1'b0}};
                ent_instr_q[i] <= {INSTR_W{1'b0}};
            end
            ent_filled_q <= {DEPTH{1'b0}};
        end else if (bus.redirect_valid) begin
            ent_filled_q <= {DEPTH{1'b0}};
        end else begin
            if (req_fire_s) begin
                ent_pc_q[alloc_q]     <= pc_q;
                ent_filled_q[alloc_q] <= 1'b0;
            end
            if (rsp_fill_s) begin
                ent_instr_q[fill_q]  <= bus.imem_rsp_data;
                ent_filled_q[fill_q] <= 1'b1;
            end
        end
    end

    fetch_prefetch_unit_chk u_chk (
        .clk         (clk),
        .reset_n     (reset_n),
        .rsp_valid_i (bus.imem_rsp_valid),
        .redirect_i  (bus.redirect_valid),
        .drop_zero_i (drop_q == DROP_ZERO),
        .pend_zero_i (pend_q == CNT_ZERO)
    );
endmodule
